bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-add-3 / double-dabble).
//  Successor to the 4-bit combinational converter: generic input width and digit count,
//  optional signed mode, start/busy/done handshake and overflow flag.
//  Sits between arithmetic datapaths (adder/subtractor results) and 7-segment display drivers.
// PARAMETERS
//  WIDTH   8  binary input width in bits (>=2)
//  DIGITS  3  BCD output digits; output width 4*DIGITS
//  SIGNED  0  1: b is two's complement; magnitude converted, sign on neg
// PORTS
//  clk    in   1         single clock; all state on rising edge
//  rst_n  in   1         asynchronous, active-low reset
//  start  in   1         conversion request; sampled only in IDLE
//  b      in   WIDTH     binary operand; captured on accepted start
//  busy   out  1         high from the cycle after accept until done
//  done   out  1         one-cycle pulse: d/neg/ovf valid
//  d      out  4*DIGITS  packed BCD, digit 0 in d[3:0]; held until next done
//  neg    out  1         SIGNED=1 and captured b negative; tied 0 if SIGNED=0
//  ovf    out  1         result did not fit in DIGITS digits; valid with d
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, d=0, neg=0, ovf=0, shift count=0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : start=1 -> load mag = (SIGNED && b[WIDTH-1]) ? -b : b (WIDTH-bit unsigned,
//          so most-negative maps to 2^(WIDTH-1)); scratch BCD=0; cnt=0; ovf_int=0; -> SHIFT.
//   SHIFT: per cycle: every digit >=5 gets +3, then {bcd,mag} shifted left 1;
//          a 1 leaving the top digit sets ovf_int (sticky). cnt+1; after WIDTH shifts -> DONE.
//   DONE : d<=scratch, neg<=captured sign, ovf<=ovf_int, done=1 for this cycle -> IDLE.
//  Latency: start accepted at edge N -> done high in cycle N+WIDTH+1; throughput 1 per WIDTH+2.
//  busy=1 in SHIFT and DONE; 0 in IDLE. Back-to-back: start high in cycle after done accepted.
//  start while busy: ignored, no queueing; b changes while busy: no effect.
//  start held high: restarts each time FSM returns to IDLE.
//  ovf=1: d holds the low DIGITS digits (modulo 10^DIGITS); neg still valid.
//  b=0 / neg zero impossible: neg=0 whenever magnitude is 0.
//  Reset mid-conversion: all outputs to reset values immediately; no done pulse.
//  Outputs d/neg/ovf change only in DONE or reset; stable otherwise.
// STRUCTURE
//  Package bin_bcd_pkg: state enum {IDLE,SHIFT,DONE}; localparam BCD_W=4*DIGITS helper;
//   function cnt_width(WIDTH) for the shift counter ($clog2(WIDTH+1)).
//  Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", instantiated DIGITS times
//   via generate; top holds FSM, counter, scratch shift register and output registers.
// TESTING (bench drives clk 10 ns, checks d/neg/ovf at done, counts cycles)
//  1 WIDTH=4 DIGITS=2: sweep b=0..15 -> d=8'h00..8'h15 (e.g. b=12 -> 8'h12), done at +5 cycles.
//  2 WIDTH=8 DIGITS=3: b=255 -> d=12'h255, ovf=0; b=0 -> 12'h000; b=99 -> 12'h099; done at +9.
//  3 WIDTH=8 DIGITS=2: b=200 -> ovf=1, d=8'h00; b=99 -> ovf=0, d=8'h99.
//  4 SIGNED=1 WIDTH=8: b=8'h80 -> neg=1 d=12'h128; b=8'hFF -> neg=1 d=12'h001; b=8'h7F -> neg=0 d=12'h127.
//  5 start pulsed at cycles +3 and +5 of a conversion of 42 -> ignored; single done, d=12'h042.
//  6 rst_n low at SHIFT cycle 4 -> busy/done/d/ovf=0 at once; no done; next start converts normally.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DIGIT_W = 4;

    // Packed BCD width for a given digit count.
    function automatic int unsigned bcd_width(input int unsigned digits);
        return DIGIT_W * digits;
    endfunction

    // Shift counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of double-dabble: values of 5 or more get +3
// so the following left shift carries into the next digit at 10.
module bcd_digit_adj
    import bin_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] adj_o_c
);

    always_comb begin
        adj_o_c = digit_i;
        if (digit_i >= DIGIT_W'(5)) begin
            adj_o_c = digit_i + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock, with
// start/busy/done handshake, optional two's-complement input and overflow flag.
module bin_to_bcd_seq
    import bin_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [WIDTH-1:0]               b,
    output logic                           busy,
    output logic                           done,
    output logic [bcd_width(DIGITS)-1:0]   d,
    output logic                           neg,
    output logic                           ovf
);

    localparam int unsigned BCD_W = bcd_width(DIGITS);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               ovf_int_q, ovf_int_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   d_q, d_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   adj_c;
    logic               is_neg_c;

    // Per-digit add-3 correction applied to the scratch register before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .adj_o_c (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign is_neg_c = SIGNED && b[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        ovf_int_d = ovf_int_q;
        done_d    = 1'b0;
        d_d       = d_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Most-negative input wraps to 2^(WIDTH-1), which is its true magnitude.
                    mag_d     = is_neg_c ? WIDTH'(~b + WIDTH'(1)) : b;
                    sign_d    = is_neg_c;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_int_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d     = {adj_c[BCD_W-2:0], mag_q[WIDTH-1]};
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                ovf_int_d = ovf_int_q | adj_c[BCD_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(WIDTH)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                d_d     = bcd_q;
                neg_d   = sign_q;
                ovf_d   = ovf_int_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            ovf_int_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            d_q       <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            ovf_int_q <= ovf_int_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            d_q       <= d_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq across four parameter sets plus handshake corner cases.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic [3:0]  start_v;
    logic [7:0]  b_v;
    int          sel;
    int          total;
    int          bad;

    logic        busy0, done0, neg0, ovf0;
    logic        busy1, done1, neg1, ovf1;
    logic        busy2, done2, neg2, ovf2;
    logic        busy3, done3, neg3, ovf3;
    logic [7:0]  d0;
    logic [11:0] d1;
    logic [7:0]  d2;
    logic [11:0] d3;

    logic        cur_busy, cur_done, cur_neg, cur_ovf;
    logic [11:0] cur_d;

    typedef struct {
        int          inst;
        logic [7:0]  b;
        logic [11:0] d;
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    int   lat_of [4] = '{5, 9, 9, 9};

    bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2), .SIGNED(1'b0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .b(b_v[3:0]),
        .busy(busy0), .done(done0), .d(d0), .neg(neg0), .ovf(ovf0));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_w8d3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .b(b_v),
        .busy(busy1), .done(done1), .d(d1), .neg(neg1), .ovf(ovf1));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b0)) u_w8d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .b(b_v),
        .busy(busy2), .done(done2), .d(d2), .neg(neg2), .ovf(ovf2));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .b(b_v),
        .busy(busy3), .done(done3), .d(d3), .neg(neg3), .ovf(ovf3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_busy = busy0; cur_done = done0; cur_d = {4'h0, d0}; cur_neg = neg0; cur_ovf = ovf0;
        case (sel)
            1: begin cur_busy = busy1; cur_done = done1; cur_d = d1;           cur_neg = neg1; cur_ovf = ovf1; end
            2: begin cur_busy = busy2; cur_done = done2; cur_d = {4'h0, d2};   cur_neg = neg2; cur_ovf = ovf2; end
            3: begin cur_busy = busy3; cur_done = done3; cur_d = d3;           cur_neg = neg3; cur_ovf = ovf3; end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int inst, input logic [7:0] bv, input logic [11:0] dv,
                                input logic nv, input logic ov);
        vec_t v;
        v.inst = inst; v.b = bv; v.d = dv; v.neg = nv; v.ovf = ov;
        return v;
    endfunction

    // Pulse start for one accepting edge, then wait (bounded) for done.
    task automatic convert(input int inst, input logic [7:0] bv, output int lat, output logic got);
        sel = inst;
        b_v = bv;
        start_v[inst] = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        chk($sformatf("busy_after_accept_i%0d", inst), 32'(cur_busy), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (cur_done) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        int   cnt;
        logic got;

        total = 0; bad = 0; sel = 0;
        rst_n = 1'b0; start_v = '0; b_v = '0;

        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 8'(i), 12'((i / 10) * 16 + (i % 10)), 1'b0, 1'b0));
        vecs.push_back(mk(1, 8'd255, 12'h255, 1'b0, 1'b0));
        vecs.push_back(mk(1, 8'd0,   12'h000, 1'b0, 1'b0));
        vecs.push_back(mk(1, 8'd99,  12'h099, 1'b0, 1'b0));
        vecs.push_back(mk(1, 8'd128, 12'h128, 1'b0, 1'b0));
        vecs.push_back(mk(2, 8'd200, 12'h000, 1'b0, 1'b1));
        vecs.push_back(mk(2, 8'd99,  12'h099, 1'b0, 1'b0));
        vecs.push_back(mk(2, 8'd100, 12'h000, 1'b0, 1'b1));
        vecs.push_back(mk(2, 8'd255, 12'h055, 1'b0, 1'b1));
        vecs.push_back(mk(3, 8'h80,  12'h128, 1'b1, 1'b0));
        vecs.push_back(mk(3, 8'hFF,  12'h001, 1'b1, 1'b0));
        vecs.push_back(mk(3, 8'h7F,  12'h127, 1'b0, 1'b0));
        vecs.push_back(mk(3, 8'h00,  12'h000, 1'b0, 1'b0));
        vecs.push_back(mk(3, 8'hD6,  12'h042, 1'b1, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            sel = i; #1;
            chk($sformatf("reset_busy_i%0d", i), 32'(cur_busy), 32'd0);
            chk($sformatf("reset_done_i%0d", i), 32'(cur_done), 32'd0);
            chk($sformatf("reset_d_i%0d", i),    32'(cur_d),    32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            convert(vecs[i].inst, vecs[i].b, lat, got);
            chk($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
            chk($sformatf("v%0d_latency", i),   32'(lat), 32'(lat_of[vecs[i].inst]));
            chk($sformatf("v%0d_d", i),         32'(cur_d),   32'(vecs[i].d));
            chk($sformatf("v%0d_neg", i),       32'(cur_neg), 32'(vecs[i].neg));
            chk($sformatf("v%0d_ovf", i),       32'(cur_ovf), 32'(vecs[i].ovf));
        end

        // Done is a single-cycle pulse and d holds afterwards.
        @(posedge clk); #1;
        chk("done_pulse_width", 32'(cur_done), 32'd0);
        chk("d_held",           32'(cur_d),    32'h042);

        // Start requests while busy are dropped; b changes have no effect.
        sel = 1; b_v = 8'd42; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        got = 1'b0; lat = 0;
        for (int k = 1; k <= 40; k++) begin
            b_v = 8'd99;
            start_v[1] = (k == 2 || k == 4);
            @(posedge clk); #1;
            start_v = '0;
            if (cur_done) begin lat = k; got = 1'b1; break; end
        end
        chk("busy_start_done_seen", 32'(got),   32'd1);
        chk("busy_start_latency",   32'(lat),   32'd9);
        chk("busy_start_d",         32'(cur_d), 32'h042);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (cur_done) cnt++;
        end
        chk("busy_start_no_extra_done", 32'(cnt), 32'd0);

        // Start held high restarts every WIDTH+2 cycles.
        sel = 1; b_v = 8'd7; start_v[1] = 1'b1;
        @(posedge clk); #1;
        got = 1'b0; lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (cur_done) begin lat = k; got = 1'b1; break; end
        end
        chk("held_first_latency", 32'(lat), 32'd9);
        got = 1'b0; lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (cur_done) begin lat = k; got = 1'b1; break; end
        end
        start_v = '0;
        chk("held_second_done_seen", 32'(got),   32'd1);
        chk("held_period",           32'(lat),   32'd10);
        chk("held_d",                32'(cur_d), 32'h007);
        repeat (12) @(posedge clk);
        #1;

        // Reset in the middle of a conversion.
        sel = 1; b_v = 8'd42; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(cur_busy), 32'd0);
        chk("midrst_done", 32'(cur_done), 32'd0);
        chk("midrst_d",    32'(cur_d),    32'd0);
        chk("midrst_ovf",  32'(cur_ovf),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (cur_done) cnt++;
        end
        chk("midrst_no_done", 32'(cnt), 32'd0);
        convert(1, 8'd99, lat, got);
        chk("post_rst_done_seen", 32'(got),   32'd1);
        chk("post_rst_latency",   32'(lat),   32'd9);
        chk("post_rst_d",         32'(cur_d), 32'h099);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
